hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage core. It generates the per-stage stall and flush strobes that drive the IF/ID, ID/EX and EX/M pipeline registers, where stall means hold the register and flush means inject a NOP. It also owns the multi-cycle HI/LO multiply/divide sequencer, so instructions that depend on an unfinished mul/div are held in ID until the result is ready.

## Interface
- MULT_CYCLES, 4: execution cycles of a MULT/MULTU.
- DIV_CYCLES, 32: execution cycles of a DIV/DIVU; must be >= MULT_CYCLES.
- CW, $clog2(DIV_CYCLES+1): counter width (derived, not overridden).

- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- ID_Rs, ID_Rt  in  5 each  source register numbers of the instruction in ID.
- ID_WantRs, ID_WantRt  in  1 each  ID instruction reads Rs / Rt in EX.
- ID_NeedRsInID, ID_NeedRtInID  in  1 each  ID instruction (branch/jr) needs Rs / Rt during ID.
- ID_MulDiv  in  1  ID instruction is MULT/MULTU/DIV/DIVU.
- ID_ReadsHiLo  in  1  ID instruction is MFHI/MFLO/MTHI/MTLO.
- EX_Dst  in  5  destination register of the EX instruction.
- EX_RegWrite, EX_MemRead  in  1 each  EX instruction writes a register / is a load.
- EX_MulDiv, EX_IsDiv  in  1 each  EX instruction is a mul/div / is a divide.
- M_Dst  in  5  destination register of the M instruction.
- M_MemRead  in  1  M instruction is a load.
- M_Exception  in  1  exception taken by the instruction in M.
- IMem_Stall, DMem_Stall  in  1 each  instruction / data memory not ready.
- IF_Stall, ID_Stall, EX_Stall, M_Stall  out  1 each  hold the respective stage.
- IF_Flush, ID_Flush, EX_Flush  out  1 each  squash the respective stage.
- MD_Busy  out  1  mul/div sequencer in BUSY.
- MD_Done  out  1  one-cycle pulse; HI/LO are written at the end of this cycle.
- MD_IsDiv  out  1  latched operation type of the running mul/div.
- MD_Count  out  CW  remaining cycles, counting down.

## Operation
- Match(r, d) = (r == d) & (d != 0). Register 0 never causes a hazard.
- LoadUse = EX_MemRead & ((ID_WantRs & Match(ID_Rs, EX_Dst)) | (ID_WantRt & Match(ID_Rt, EX_Dst))).
- BranchHaz = (ID_NeedRsInID & ((EX_RegWrite & Match(ID_Rs, EX_Dst)) | (M_MemRead & Match(ID_Rs, M_Dst)))), plus the same term with ID_NeedRtInID and ID_Rt.
- HiLoHaz = ID_ReadsHiLo & (MD_Busy | EX_MulDiv).
- MDHaz = ID_MulDiv & (MD_Busy | EX_MulDiv).
- Stall chain (combinational):
  - M_Stall = DMem_Stall.
  - EX_Stall = M_Stall.
  - ID_Stall = EX_Stall | LoadUse | BranchHaz | HiLoHaz | MDHaz.
  - IF_Stall = ID_Stall | IMem_Stall.
- Flush: IF_Flush = ID_Flush = EX_Flush = M_Exception. Flush overrides stall for IF/ID/EX; M_Stall is still honoured.
- Sequencer states:
  - IDLE, and Start = EX_MulDiv & ~EX_Stall & ~EX_Flush: go to BUSY; MD_Count <= (EX_IsDiv ? DIV_CYCLES : MULT_CYCLES) - 1; MD_IsDiv <= EX_IsDiv.
  - BUSY, MD_Count != 0: decrement.
  - BUSY, MD_Count == 0: MD_Done = 1 (combinational: state==BUSY & MD_Count==0); go to IDLE next.
- Because start happens at the EX→M commit, a started op is older than any M exception. M_Exception and DMem_Stall never cancel or pause the sequencer.
- Start while BUSY cannot occur because MDHaz prevents it. If it does occur, the input is ignored and the assertion must fire in simulation.

## Timing
- Async reset (RST_N=0): state IDLE, MD_Count=0, MD_IsDiv=0, MD_Busy=0, MD_Done=0. Stall/flush outputs remain purely combinational from inputs.
- Reset deassertion is synchronous to CLK by the external reset synchroniser. A reset mid-operation drops BUSY immediately and produces no MD_Done.
- Start in cycle T: MD_Busy=1 in cycles T+1..T+N (N = op cycles); MD_Done=1 in T+N only; MD_Busy=0 at T+N+1.
- A HI/LO reader in ID stalls from T through T+N and advances at T+N+1.
- A load-use hazard costs exactly one bubble: the load reaches M, LoadUse drops, and the consumer advances.
- A branch on a load result costs two bubbles: one for EX_RegWrite, one for M_MemRead.
- Stalls and flushes carry zero latency (combinational). The sequencer has a one-cycle latency from Start to Busy.

## Test plan
- Load-use: EX_MemRead=1, EX_Dst=5, ID_Rs=5, ID_WantRs=1 → ID_Stall=IF_Stall=1 for one cycle. Repeat with EX_Dst=0 → no stall.
- Branch on load: M_MemRead=1, M_Dst=7, ID_NeedRsInID=1, ID_Rs=7 → ID_Stall=1. Repeat with the register write coming from EX_RegWrite (same Dst) → ID_Stall=1.
- MULT then MFHI: Start at T=10, default params → MD_Busy=1 for cycles 11–14, MD_Done=1 at 14, ID_Stall=1 for cycles 10–14 with ID_ReadsHiLo=1.
- DIV back-to-back: second ID_MulDiv is stalled until MD_Busy falls; MD_Count reloads 31; MD_Done is exactly 32 cycles after the second Start.
- M_Exception=1 during BUSY → all three flushes=1 that cycle; sequencer continues and MD_Done still occurs at the scheduled cycle.
- DMem_Stall=1 while Start conditions hold → M_Stall=EX_Stall=ID_Stall=1 and no Start. RST_N pulsed low mid-BUSY → MD_Busy=0 immediately and no MD_Done.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush generation and the
// multi-cycle HI/LO multiply/divide sequencer.
module hazard_ctrl #(
    parameter  int MULT_CYCLES = 4,
    parameter  int DIV_CYCLES  = 32,
    localparam int CW          = $clog2(DIV_CYCLES + 1)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [4:0]    ID_Rs,
    input  logic [4:0]    ID_Rt,
    input  logic          ID_WantRs,
    input  logic          ID_WantRt,
    input  logic          ID_NeedRsInID,
    input  logic          ID_NeedRtInID,
    input  logic          ID_MulDiv,
    input  logic          ID_ReadsHiLo,
    input  logic [4:0]    EX_Dst,
    input  logic          EX_RegWrite,
    input  logic          EX_MemRead,
    input  logic          EX_MulDiv,
    input  logic          EX_IsDiv,
    input  logic [4:0]    M_Dst,
    input  logic          M_MemRead,
    input  logic          M_Exception,
    input  logic          IMem_Stall,
    input  logic          DMem_Stall,
    output logic          IF_Stall,
    output logic          ID_Stall,
    output logic          EX_Stall,
    output logic          M_Stall,
    output logic          IF_Flush,
    output logic          ID_Flush,
    output logic          EX_Flush,
    output logic          MD_Busy,
    output logic          MD_Done,
    output logic          MD_IsDiv,
    output logic [CW-1:0] MD_Count
);

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    md_state_t     state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          is_div_q, is_div_d;

    logic load_use;
    logic branch_haz;
    logic hilo_haz;
    logic md_haz;
    logic flush;
    logic ex_stall_raw;
    logic id_stall_raw;
    logic if_stall_raw;
    logic start;

    // Register 0 is hardwired, so writes to it never create a hazard.
    function automatic logic match(input logic [4:0] r, input logic [4:0] d);
        return (r == d) && (d != 5'd0);
    endfunction

    // Hazard detection and the combinational stall/flush chain.
    always_comb begin
        load_use = EX_MemRead &
                   ((ID_WantRs & match(ID_Rs, EX_Dst)) |
                    (ID_WantRt & match(ID_Rt, EX_Dst)));

        branch_haz =
            (ID_NeedRsInID &
             ((EX_RegWrite & match(ID_Rs, EX_Dst)) |
              (M_MemRead   & match(ID_Rs, M_Dst)))) |
            (ID_NeedRtInID &
             ((EX_RegWrite & match(ID_Rt, EX_Dst)) |
              (M_MemRead   & match(ID_Rt, M_Dst))));

        hilo_haz = ID_ReadsHiLo & (MD_Busy | EX_MulDiv);
        md_haz   = ID_MulDiv    & (MD_Busy | EX_MulDiv);

        flush        = M_Exception;
        M_Stall      = DMem_Stall;
        ex_stall_raw = M_Stall;
        id_stall_raw = ex_stall_raw | load_use | branch_haz |
                       hilo_haz | md_haz;
        if_stall_raw = id_stall_raw | IMem_Stall;

        // A flushed stage is squashed, so holding it is meaningless.
        EX_Stall = ex_stall_raw & ~flush;
        ID_Stall = id_stall_raw & ~flush;
        IF_Stall = if_stall_raw & ~flush;

        IF_Flush = flush;
        ID_Flush = flush;
        EX_Flush = flush;

        // The op starts as it commits from EX into M.
        start = EX_MulDiv & ~ex_stall_raw & ~flush;
    end

    // Sequencer next-state: load on start, count down while busy.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        is_div_d = is_div_q;
        unique case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d  = MD_BUSY;
                    is_div_d = EX_IsDiv;
                    count_d  = EX_IsDiv ? CW'(DIV_CYCLES - 1)
                                        : CW'(MULT_CYCLES - 1);
                end
            end
            MD_BUSY: begin
                if (count_q == '0) begin
                    state_d = MD_IDLE;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= MD_IDLE;
            count_q  <= '0;
            is_div_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            is_div_q <= is_div_d;
        end
    end

    // Sequencer status outputs.
    always_comb begin
        MD_Busy  = (state_q == MD_BUSY);
        MD_Done  = (state_q == MD_BUSY) && (count_q == '0);
        MD_IsDiv = is_div_q;
        MD_Count = count_q;
    end

    // A second start while busy is dropped; it means MDHaz was bypassed.
    a_no_start_busy : assert property (
        @(posedge CLK) disable iff (!RST_N) !(MD_Busy && start)
    );

endmodule
